// File: rtl/bnn_pkg.sv
// bnn_pkg: shared FSM state type and width helpers for the binary
// neural network classifier.
package bnn_pkg;

    // Controller phases: wait for features, hidden layer, output layer, hold result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_L0   = 2'd1,
        ST_L1   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A signed sum of FEAT_CNT unsigned FEAT_BITS terms needs log2 growth
    // plus one sign bit, so it can never overflow.
    function automatic int sum_width(input int feat_cnt, input int feat_bits);
        return feat_bits + $clog2(feat_cnt) + 1;
    endfunction

    // A popcount over HIDDEN_CNT bits ranges 0..HIDDEN_CNT inclusive.
    function automatic int score_width(input int hidden_cnt);
        return $clog2(hidden_cnt + 1);
    endfunction

endpackage

// File: rtl/bnn_l0_neuron.sv
// bnn_l0_neuron: one binary hidden neuron. Adds each feature whose weight
// bit is 1 and subtracts each feature whose weight bit is 0; the neuron
// fires when the signed sum is non-negative. Purely combinational.
module bnn_l0_neuron
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT  = 19,
    parameter int FEAT_BITS = 4
) (
    input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [FEAT_CNT-1:0]           weights,
    output logic                          hidden
);

    localparam int SW = sum_width(FEAT_CNT, FEAT_BITS);

    logic signed [SW-1:0] sum;

    // Signed accumulation of +f_i / -f_i across all features.
    always_comb begin
        // NOTE: every variable driven here gets a default first, otherwise a path that skips the assignment infers a latch.
        sum = '0;
        for (int i = 0; i < FEAT_CNT; i++) begin
            if (weights[i]) sum = sum + SW'(features[i*FEAT_BITS +: FEAT_BITS]);
            else            sum = sum - SW'(features[i*FEAT_BITS +: FEAT_BITS]);
        end
        hidden = ~sum[SW-1];
    end

endmodule

// File: rtl/bnn_seq_hs.sv
// bnn_seq_hs: sequential two-layer binary neural network classifier with
// valid/ready handshakes. Hidden neurons are evaluated one per cycle, then
// classes one per cycle with a running argmax (ties keep the lower index).
// Optional feature: define BNN_SCORE_OUT_EN to add the winning-score port.
module bnn_seq_hs
    import bnn_pkg::*;
#(
    parameter int                               FEAT_CNT   = 19,
    parameter int                               FEAT_BITS  = 4,
    parameter int                               HIDDEN_CNT = 40,
    parameter int                               CLASS_CNT  = 3,
    parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]   Weights0   = '0,
    parameter logic [HIDDEN_CNT*CLASS_CNT-1:0]  Weights1   = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [FEAT_CNT*FEAT_BITS-1:0]     features,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(CLASS_CNT)-1:0]      prediction
`ifdef BNN_SCORE_OUT_EN
    ,
    output logic [score_width(HIDDEN_CNT)-1:0] score
`endif
);

    localparam int HIW = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
    localparam int CIW = $clog2(CLASS_CNT);
    localparam int SCW = score_width(HIDDEN_CNT);

    state_t                        state, next_state;
    logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
    logic [HIDDEN_CNT-1:0]         hidden_q;
    logic [HIW-1:0]                hid_idx;
    logic [CIW-1:0]                cls_idx;
    logic [SCW-1:0]                best_score;
    logic [CIW-1:0]                best_idx;
    logic [CIW-1:0]                pred_q;

    logic [FEAT_CNT-1:0]           w0_row;
    logic [HIDDEN_CNT-1:0]         w1_row;
    logic                          hid_bit;
    logic [SCW-1:0]                cls_score;
    logic                          win_take;
    logic [CIW-1:0]                win_idx;
    logic [SCW-1:0]                win_score;
    logic                          hid_last;
    logic                          cls_last;

    assign w0_row   = Weights0[int'(hid_idx)*FEAT_CNT +: FEAT_CNT];
    assign w1_row   = Weights1[int'(cls_idx)*HIDDEN_CNT +: HIDDEN_CNT];
    assign hid_last = (hid_idx == HIW'(HIDDEN_CNT - 1));
    assign cls_last = (cls_idx == CIW'(CLASS_CNT - 1));

    bnn_l0_neuron #(
        .FEAT_CNT  (FEAT_CNT),
        .FEAT_BITS (FEAT_BITS)
    ) u_neuron (
        .features (feat_q),
        .weights  (w0_row),
        .hidden   (hid_bit)
    );

    // Class score (XNOR popcount) and the running argmax candidate.
    always_comb begin
        cls_score = '0;
        for (int j = 0; j < HIDDEN_CNT; j++) begin
            cls_score = cls_score + SCW'(hidden_q[j] ~^ w1_row[j]);
        end
        win_take  = (cls_idx == '0) || (cls_score > best_score);
        win_idx   = win_take ? cls_idx : best_idx;
        win_score = win_take ? cls_score : best_score;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = ST_L0;
            end
            ST_L0:   if (hid_last) next_state = ST_L1;
            ST_L1:   if (cls_last) next_state = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Feature capture register, loaded on every accepted transaction.
    always_ff @(posedge clk) begin
        // NOTE: pure data register with no reset; it is always written before any stage reads it.
        if (state == ST_IDLE && in_valid) feat_q <= features;
    end

    // Datapath: hidden vector, layer counters, running argmax and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hidden_q   <= '0;
            hid_idx    <= '0;
            cls_idx    <= '0;
            best_score <= '0;
            best_idx   <= '0;
            pred_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        hid_idx <= '0;
                        cls_idx <= '0;
                    end
                end
                ST_L0: begin
                    hidden_q[hid_idx] <= hid_bit;
                    hid_idx           <= hid_last ? '0 : hid_idx + 1'b1;
                end
                ST_L1: begin
                    best_score <= win_score;
                    best_idx   <= win_idx;
                    cls_idx    <= cls_last ? '0 : cls_idx + 1'b1;
                    if (cls_last) pred_q <= win_idx;
                end
                default: ;
            endcase
        end
    end

    assign prediction = pred_q;

`ifdef BNN_SCORE_OUT_EN
    logic [SCW-1:0] score_q;

    // Winning score, loaded together with the prediction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          score_q <= '0;
        else if (state == ST_L1 && cls_last) score_q <= win_score;
    end

    assign score = score_q;
`endif

endmodule

// File: tb/tb_bnn_seq_hs.sv
// tb_bnn_seq_hs: three classifier instances with different weight sets
// share one stimulus stream and are checked every cycle against a
// behavioural model, plus hand-computed literal expectations.
module tb_bnn_seq_hs;

    localparam int FC = 2;
    localparam int FB = 4;
    localparam int HC = 2;
    localparam int CC = 3;
    localparam int ND = 3;

    localparam logic [FC*HC-1:0] W0_TAB [ND] = '{4'b1111, 4'b1111, 4'b0000};
    localparam logic [HC*CC-1:0] W1_TAB [ND] = '{6'b110001, 6'b001111, 6'b110001};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [FC*FB-1:0] features = '0;

    logic           in_ready_v  [ND];
    logic           out_valid_v [ND];
    logic [1:0]     pred_v      [ND];
`ifdef BNN_SCORE_OUT_EN
    logic [1:0]     score_v     [ND];
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bnn_seq_hs #(.FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
                 .Weights0(W0_TAB[0]), .Weights1(W1_TAB[0])) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .features(features), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .prediction(pred_v[0])
`ifdef BNN_SCORE_OUT_EN
        , .score(score_v[0])
`endif
    );

    bnn_seq_hs #(.FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
                 .Weights0(W0_TAB[1]), .Weights1(W1_TAB[1])) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .features(features), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .prediction(pred_v[1])
`ifdef BNN_SCORE_OUT_EN
        , .score(score_v[1])
`endif
    );

    bnn_seq_hs #(.FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
                 .Weights0(W0_TAB[2]), .Weights1(W1_TAB[2])) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .features(features), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .prediction(pred_v[2])
`ifdef BNN_SCORE_OUT_EN
        , .score(score_v[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Straight from the network definition: integer sums, threshold, popcount, argmax.
    task automatic predict(input logic [FC*HC-1:0] w0, input logic [HC*CC-1:0] w1,
                           input logic [FC*FB-1:0] f, output int pred, output int best,
                           output logic [HC-1:0] hid);
        int s, sc;
        best = -1;
        pred = 0;
        for (int j = 0; j < HC; j++) begin
            s = 0;
            for (int i = 0; i < FC; i++) begin
                if (w0[j*FC+i]) s += int'(f[i*FB +: FB]);
                else            s -= int'(f[i*FB +: FB]);
            end
            hid[j] = (s >= 0);
        end
        for (int k = 0; k < CC; k++) begin
            sc = 0;
            for (int j = 0; j < HC; j++) if (hid[j] == w1[k*HC+j]) sc++;
            if (sc > best) begin
                best = sc;
                pred = k;
            end
        end
    endtask

    // Model: a transaction accepted in idle produces its result HC+CC edges later,
    // held until the consumer takes it; the last result is retained.
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    int          m_cnt = 0;
    int          pend_pred [ND];
    int          pend_score [ND];
    logic [HC-1:0] m_hid [ND];
    int          exp_pred [ND] = '{0, 0, 0};
    int          exp_score [ND] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
            for (int d = 0; d < ND; d++) begin
                exp_pred[d]  = 0;
                exp_score[d] = 0;
            end
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == HC + CC) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
                for (int d = 0; d < ND; d++) begin
                    exp_pred[d]  = pend_pred[d];
                    exp_score[d] = pend_score[d];
                end
            end
        end else if (in_valid) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            for (int d = 0; d < ND; d++)
                predict(W0_TAB[d], W1_TAB[d], features, pend_pred[d], pend_score[d], m_hid[d]);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            check($sformatf("dut%0d in_ready", d), 32'(in_ready_v[d]), 32'(!(m_busy || m_valid)));
            check($sformatf("dut%0d out_valid", d), 32'(out_valid_v[d]), 32'(m_valid));
            check($sformatf("dut%0d prediction", d), 32'(pred_v[d]), 32'(exp_pred[d]));
`ifdef BNN_SCORE_OUT_EN
            if (m_valid) check($sformatf("dut%0d score", d), 32'(score_v[d]), 32'(exp_score[d]));
`endif
        end
    end

    // One inference with literal expectations; hold cycles keep out_ready low.
    task automatic run(input logic [FC*FB-1:0] f, input int pa, input int pb, input int pc,
                       input logic [HC-1:0] ha, input logic [HC-1:0] hc, input int hold);
        int lat;
        logic [1:0] held [ND];
        features = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        features = ~f;
        lat = 0;
        while (!out_valid_v[0] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(HC + CC));
        check("pred a literal", 32'(pred_v[0]), 32'(pa));
        check("pred b literal", 32'(pred_v[1]), 32'(pb));
        check("pred c literal", 32'(pred_v[2]), 32'(pc));
        check("model pred c literal", 32'(exp_pred[2]), 32'(pc));
        check("model hidden a literal", 32'(m_hid[0]), 32'(ha));
        check("hidden a", 32'(u_a.hidden_q), 32'(ha));
        check("hidden c", 32'(u_c.hidden_q), 32'(hc));
        for (int d = 0; d < ND; d++) held[d] = pred_v[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            features = FC*FB'($urandom);
            check("hold out_valid", 32'(out_valid_v[0]), 32'd1);
            check("hold in_ready", 32'(in_ready_v[0]), 32'd0);
            for (int d = 0; d < ND; d++) check("hold prediction", 32'(pred_v[d]), 32'(held[d]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("after handshake out_valid", 32'(out_valid_v[0]), 32'd0);
        check("after handshake in_ready", 32'(in_ready_v[0]), 32'd1);
        check("retained prediction a", 32'(pred_v[0]), 32'(pa));
    endtask

    initial begin
        int seen;
        #2;
        for (int d = 0; d < ND; d++) begin
            check("reset in_ready", 32'(in_ready_v[d]), 32'd1);
            check("reset out_valid", 32'(out_valid_v[d]), 32'd0);
            check("reset prediction", 32'(pred_v[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run(8'h35, 2, 0, 1, 2'b11, 2'b00, 0);
        run(8'h10, 2, 0, 1, 2'b11, 2'b00, 10);
        run(8'h00, 2, 0, 2, 2'b11, 2'b11, 0);

        // Abort one cycle into the hidden layer.
        features = 8'h35;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check("abort in_ready", 32'(in_ready_v[d]), 32'd1);
            check("abort out_valid", 32'(out_valid_v[d]), 32'd0);
            check("abort prediction", 32'(pred_v[d]), 32'd0);
        end
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid_v[0]) seen++;
        end
        check("no out_valid after abort", 32'(seen), 32'd0);
        run(8'h35, 2, 0, 1, 2'b11, 2'b00, 0);

        // Reset while a result is held must clear it at once.
        features = 8'h00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (HC + CC) @(posedge clk);
        #1;
        check("done before reset", 32'(out_valid_v[2]), 32'd1);
        check("done pred c", 32'(pred_v[2]), 32'd2);
        rst = 1'b1;
        #1;
        check("reset in done out_valid", 32'(out_valid_v[2]), 32'd0);
        check("reset in done prediction", 32'(pred_v[2]), 32'd0);
        check("reset in done in_ready", 32'(in_ready_v[2]), 32'd1);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
